// File: rtl/core_wb_pkg.sv
// Shared types for the register-file write-back scheduler: request record,
// grant encoding and architectural register count.
package core_wb_pkg;
  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = $clog2(REG_NUM);
  localparam int WORD_W    = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [WORD_W-1:0]    data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LSU
  } grant_e;
endpackage

// File: rtl/core_wb_fifo.sv
// Load-return buffer: small synchronous FIFO exposing its head plus per-entry
// valid/rd so the parent can build a pending-write mask.
module core_wb_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_rd,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [$clog2(DEPTH):0]        cnt,
  output logic                          full,
  output logic [ADDR_W-1:0]             head_rd,
  output logic [DATA_W-1:0]             head_data,
  output logic [DEPTH-1:0]              ent_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_rd
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_mem_d [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic              push_ok, pop_ok;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (cnt_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (push_ok) begin
      rd_mem_d[wr_ptr_q]   = push_rd;
      data_mem_d[wr_ptr_q] = push_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset: an entry is only meaningful while counted valid.
  always_ff @(posedge clk) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign cnt       = cnt_q;
  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i]  = rd_mem_q[i];
      ent_vld[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < cnt_q;
    end
  end
endmodule

// File: rtl/core_wb_arbiter.sv
// Register-file write-port scheduler: ALU results vs buffered load returns,
// with ALU priority, bounded LSU starvation and WAW protection.
module core_wb_arbiter
  import core_wb_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int LSU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alu_valid,
  input  logic [ADDR_W-1:0]               alu_rd,
  input  logic [DATA_W-1:0]               alu_data,
  output logic                            alu_ready,
  input  logic                            lsu_valid,
  input  logic [ADDR_W-1:0]               lsu_rd,
  input  logic [DATA_W-1:0]               lsu_data,
  output logic                            lsu_ready,
  output logic                            rf_we,
  output logic [ADDR_W-1:0]               rf_rd,
  output logic [DATA_W-1:0]               rf_data,
  output logic [REG_NUM-1:0]              pend_mask,
  output logic [$clog2(LSU_FIFO_DEPTH):0] fifo_cnt
);
  localparam int CNT_W = $clog2(LSU_FIFO_DEPTH) + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    if (v == SW'(STARVE_LIMIT)) return v;
    return v + SW'(1);
  endfunction

  logic [CNT_W-1:0]                   cnt;
  logic                               full, head_vld, hazard, force_lsu;
  logic [ADDR_W-1:0]                  head_rd;
  logic [DATA_W-1:0]                  head_data;
  logic [LSU_FIFO_DEPTH-1:0]          ent_vld;
  logic [LSU_FIFO_DEPTH-1:0][ADDR_W-1:0] ent_rd;
  grant_e                             gnt;
  logic [SW-1:0]                      starve_q, starve_d;
  logic                               rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]                  rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0]                  rf_data_q, rf_data_d;

  assign lsu_ready = !full;

  core_wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lsu_valid && lsu_ready),
    .push_rd   (lsu_rd),
    .push_data (lsu_data),
    .pop       (gnt == GNT_LSU),
    .cnt       (cnt),
    .full      (full),
    .head_rd   (head_rd),
    .head_data (head_data),
    .ent_vld   (ent_vld),
    .ent_rd    (ent_rd)
  );

  // x0 is never a real destination, so it never blocks the ALU.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < LSU_FIFO_DEPTH; i++) begin
      if (ent_vld[i] && (ent_rd[i] != '0)) pend_mask[ent_rd[i]] = 1'b1;
    end
  end

  assign fifo_cnt  = cnt;
  assign head_vld  = (cnt != '0);
  assign hazard    = alu_valid && (alu_rd != '0) && pend_mask[alu_rd];
  assign force_lsu = (starve_q == SW'(STARVE_LIMIT));
  assign alu_ready = alu_valid && (gnt == GNT_ALU);

  always_comb begin
    gnt       = GNT_NONE;
    starve_d  = starve_q;
    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (head_vld && (!alu_valid || hazard || force_lsu)) begin
      gnt = GNT_LSU;
    end else if (alu_valid) begin
      gnt = GNT_ALU;
    end
    if (!head_vld || (gnt == GNT_LSU)) begin
      starve_d = '0;
    end else if (gnt == GNT_ALU) begin
      starve_d = sat_inc(starve_q);
    end
    if (gnt == GNT_ALU) begin
      rf_we_d   = (alu_rd != '0);
      rf_rd_d   = alu_rd;
      rf_data_d = alu_data;
    end else if (gnt == GNT_LSU) begin
      rf_we_d   = (head_rd != '0);
      rf_rd_d   = head_rd;
      rf_data_d = head_data;
    end
  end

  // Issue stage: the granted request reaches the register file one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_rd   = rf_rd_q;
  assign rf_data = rf_data_q;
endmodule

// File: tb/tb_core_wb_arbiter.sv
// Bench for core_wb_arbiter: ALU-only vector table plus directed multi-cycle
// sequences; every register-file write is matched against a queue of expectations.
module tb_core_wb_arbiter;
  import core_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [31:0] pend_mask;
  logic [1:0]  fifo_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  wb_req_t sb[$];
  wb_req_t mon_e;

  typedef struct packed {
    logic        a_v;
    logic [4:0]  a_rd;
    logic [31:0] a_d;
    logic        e_rdy;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;
  vec_t vecs [6];

  core_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .pend_mask (pend_mask),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = v; lsu_rd = rd; lsu_data = d;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    wb_req_t r;
    r.rd = rd;
    r.data = d;
    sb.push_back(r);
  endtask

  // Every issued write must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rf_we) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: write r%0d=%0h, expected no write", rf_rd, rf_data);
      end else begin
        mon_e = sb.pop_front();
        if (rf_rd !== mon_e.rd || rf_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL wb_order: got r%0d=%0h, expected r%0d=%0h",
                   rf_rd, rf_data, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd9,  32'h12345678, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h00000055, 1'b1, 1'b0, 5'd0,  32'h00000055};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 1'b1, 5'd1,  32'h00000000};
    vecs[5] = '{1'b0, 5'd2,  32'h0000CAFE, 1'b0, 1'b0, 5'd1,  32'h00000000};

    // Reset with garbage on the inputs
    rst_n = 1'b0;
    alu(1'b1, 5'd5, 32'hBAD0BAD0);
    lsu(1'b1, 5'd6, 32'hBAD1BAD1);
    repeat (3) cyc();
    rst_n = 1'b1;
    alu(1'b0, 5'd0, 32'h0);
    lsu(1'b0, 5'd0, 32'h0);
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_pend_mask", pend_mask, 0);
    chk("rst_lsu_ready", lsu_ready, 1);
    cyc();

    // ALU-only vectors, FIFO empty
    for (int i = 0; i < 6; i++) begin
      alu(vecs[i].a_v, vecs[i].a_rd, vecs[i].a_d);
      #1;
      chk("tbl_alu_ready", alu_ready, vecs[i].e_rdy);
      chk("tbl_lsu_ready", lsu_ready, 1);
      if (vecs[i].e_we) expect_wr(vecs[i].e_rd, vecs[i].e_data);
      cyc();
      chk("tbl_rf_we", rf_we, vecs[i].e_we);
      chk("tbl_rf_rd", rf_rd, vecs[i].e_rd);
      chk("tbl_rf_data", rf_data, vecs[i].e_data);
    end
    alu(1'b0, 5'd0, 32'h0);
    cyc();

    // LSU back-to-back with ALU idle
    lsu(1'b1, 5'd3, 32'h11);
    #1;
    chk("fill_lsu_ready", lsu_ready, 1);
    expect_wr(5'd3, 32'h11);
    cyc();
    lsu(1'b1, 5'd4, 32'h22);
    #1;
    chk("fill_cnt1", fifo_cnt, 1);
    chk("fill_pend3", pend_mask, 32'h8);
    expect_wr(5'd4, 32'h22);
    cyc();
    lsu(1'b0, 5'd0, 32'h0);
    #1;
    chk("fill_cnt_b", fifo_cnt, 1);
    chk("fill_pend4", pend_mask, 32'h10);
    chk("fill_wr3_rd", rf_rd, 3);
    cyc();
    chk("fill_wr4_we", rf_we, 1);
    chk("fill_wr4_rd", rf_rd, 4);
    chk("fill_wr4_data", rf_data, 32'h22);
    chk("fill_empty", fifo_cnt, 0);
    chk("fill_pend0", pend_mask, 0);
    cyc();

    // ALU busy lets the FIFO fill; a push while full is refused
    alu(1'b1, 5'd10, 32'hA0); lsu(1'b1, 5'd3, 32'h33);
    #1; chk("full_alu_rdy_a", alu_ready, 1); expect_wr(5'd10, 32'hA0);
    cyc();
    alu(1'b1, 5'd11, 32'hA1); lsu(1'b1, 5'd4, 32'h44);
    #1; chk("full_alu_rdy_b", alu_ready, 1); chk("full_cnt1", fifo_cnt, 1);
    expect_wr(5'd11, 32'hA1);
    cyc();
    alu(1'b0, 5'd0, 32'h0); lsu(1'b1, 5'd9, 32'h99);
    #1;
    chk("full_cnt2", fifo_cnt, 2);
    chk("full_lsu_ready", lsu_ready, 0);
    chk("full_pend", pend_mask, 32'h18);
    expect_wr(5'd3, 32'h33);
    expect_wr(5'd4, 32'h44);
    cyc();
    lsu(1'b0, 5'd0, 32'h0);
    #1; chk("full_drain_cnt", fifo_cnt, 1); chk("full_drain_rdy", lsu_ready, 1);
    cyc();
    chk("full_drained", fifo_cnt, 0);
    cyc();

    // Starvation: one buffered load, ALU continuously requesting
    lsu(1'b1, 5'd20, 32'h77);
    cyc();
    lsu(1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      alu(1'b1, 5'(12 + k), 32'(256 + k));
      #1;
      chk("starve_alu_win", alu_ready, 1);
      expect_wr(5'(12 + k), 32'(256 + k));
      cyc();
    end
    alu(1'b1, 5'd16, 32'h105);
    #1;
    chk("starve_forced", alu_ready, 0);
    chk("starve_pend", pend_mask, 32'h0010_0000);
    expect_wr(5'd20, 32'h77);
    cyc();
    chk("starve_resume", alu_ready, 1);
    expect_wr(5'd16, 32'h105);
    cyc();
    alu(1'b0, 5'd0, 32'h0);
    cyc();

    // WAW: ALU rd=7 behind buffered loads r5 (head) and r7
    alu(1'b1, 5'd15, 32'hB0); lsu(1'b1, 5'd5, 32'h55);
    #1; expect_wr(5'd15, 32'hB0);
    cyc();
    alu(1'b1, 5'd16, 32'hB1); lsu(1'b1, 5'd7, 32'h70);
    #1; expect_wr(5'd16, 32'hB1);
    cyc();
    alu(1'b1, 5'd7, 32'hB7); lsu(1'b0, 5'd0, 32'h0);
    #1;
    chk("waw_pend", pend_mask, 32'hA0);
    chk("waw_block1", alu_ready, 0);
    expect_wr(5'd5, 32'h55);
    cyc();
    chk("waw_block2", alu_ready, 0);
    expect_wr(5'd7, 32'h70);
    cyc();
    chk("waw_release", alu_ready, 1);
    expect_wr(5'd7, 32'hB7);
    cyc();
    alu(1'b0, 5'd0, 32'h0);
    #1;
    chk("waw_final_rd", rf_rd, 7);
    chk("waw_final_data", rf_data, 32'hB7);
    cyc();

    // x0 from both sources is consumed without a write
    alu(1'b1, 5'd0, 32'hEE);
    #1; chk("x0_alu_ready", alu_ready, 1);
    cyc();
    alu(1'b0, 5'd0, 32'h0);
    chk("x0_alu_no_we", rf_we, 0);
    lsu(1'b1, 5'd0, 32'h99);
    cyc();
    lsu(1'b0, 5'd0, 32'h0);
    #1;
    chk("x0_lsu_cnt", fifo_cnt, 1);
    chk("x0_lsu_pend", pend_mask, 0);
    cyc();
    chk("x0_lsu_popped", fifo_cnt, 0);
    cyc();
    chk("x0_lsu_no_we", rf_we, 0);

    // Mid-run reset with a full FIFO
    alu(1'b1, 5'd13, 32'hC0); lsu(1'b1, 5'd21, 32'h1);
    #1; expect_wr(5'd13, 32'hC0);
    cyc();
    alu(1'b1, 5'd14, 32'hC1); lsu(1'b1, 5'd22, 32'h2);
    #1; expect_wr(5'd14, 32'hC1);
    cyc();
    alu(1'b0, 5'd0, 32'h0); lsu(1'b0, 5'd0, 32'h0);
    #1;
    chk("mrst_cnt2", fifo_cnt, 2);
    rst_n = 1'b0;
    cyc();
    chk("mrst_we", rf_we, 0);
    chk("mrst_rd", rf_rd, 0);
    chk("mrst_data", rf_data, 0);
    chk("mrst_cnt", fifo_cnt, 0);
    chk("mrst_pend", pend_mask, 0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("mrst_no_stale", rf_we, 0);
    end
    chk("mrst_still_empty", fifo_cnt, 0);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
